// File: rtl/cla_pipe_adder.sv
// Pipelined carry look-ahead adder/subtractor: each stage resolves GRP_PER_STG
// 4-bit CLA groups and registers the carry into the next stage.
module cla_pipe_adder #(
    parameter int WIDTH       = 32,
    parameter int GRP_PER_STG = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_ci,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_s,
    output logic             o_co,
    output logic             o_ovf
);

    localparam int SW   = 4 * GRP_PER_STG;
    localparam int NSTG = WIDTH / SW;
    localparam int LAST = NSTG - 1;

    if (WIDTH % (4 * GRP_PER_STG) != 0) begin : g_width_check
        $error("cla_pipe_adder: WIDTH must be a multiple of 4*GRP_PER_STG");
    end

    // Returns {carry_out, sum[3:0]} with all four carries looked ahead from ci.
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a | b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], a ^ b ^ c[3:0]};
    endfunction

    logic [NSTG-1:0]            v_q;
    logic [NSTG-1:0][WIDTH-1:0] a_q;
    logic [NSTG-1:0][WIDTH-1:0] b_q;
    logic [NSTG-1:0][WIDTH-1:0] s_q;
    logic [NSTG-1:0]            c_q;
    logic                       ovf_q;

    logic [NSTG:0]              rdy;
    logic [NSTG-1:0]            in_v;
    logic [NSTG-1:0][WIDTH-1:0] in_a;
    logic [NSTG-1:0][WIDTH-1:0] in_b;
    logic [NSTG-1:0][WIDTH-1:0] in_s;
    logic [NSTG-1:0]            in_c;
    logic [NSTG-1:0][WIDTH-1:0] nx_s;
    logic [NSTG-1:0]            nx_c;
    logic                       ovf_nx;

    // Ready chain runs backwards from the sink; stage inputs come from the stage before.
    always_comb begin
        rdy       = '0;
        rdy[NSTG] = i_ready;
        for (int k = NSTG - 1; k >= 0; k--) begin
            rdy[k] = ~v_q[k] | rdy[k+1];
        end

        in_v    = '0;
        in_a    = '0;
        in_b    = '0;
        in_s    = '0;
        in_c    = '0;
        in_v[0] = i_valid & rdy[0];
        in_a[0] = i_a;
        in_b[0] = i_sub ? ~i_b : i_b;
        in_c[0] = i_sub ? ~i_ci : i_ci;
        for (int k = 1; k < NSTG; k++) begin
            in_v[k] = v_q[k-1];
            in_a[k] = a_q[k-1];
            in_b[k] = b_q[k-1];
            in_s[k] = s_q[k-1];
            in_c[k] = c_q[k-1];
        end
    end

    always_comb begin
        logic       carry;
        logic [4:0] grp;
        nx_s  = in_s;
        nx_c  = '0;
        carry = 1'b0;
        grp   = '0;
        for (int k = 0; k < NSTG; k++) begin
            carry = in_c[k];
            for (int j = 0; j < GRP_PER_STG; j++) begin
                grp = cla4(in_a[k][k*SW + j*4 +: 4], in_b[k][k*SW + j*4 +: 4], carry);
                nx_s[k][k*SW + j*4 +: 4] = grp[3:0];
                carry = grp[4];
            end
            nx_c[k] = carry;
        end
        ovf_nx = (in_a[LAST][WIDTH-1] == in_b[LAST][WIDTH-1])
               & (nx_s[LAST][WIDTH-1] != in_a[LAST][WIDTH-1]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k < NSTG; k++) begin
                if (rdy[k]) begin
                    v_q[k] <= in_v[k];
                    a_q[k] <= in_a[k];
                    b_q[k] <= in_b[k];
                    s_q[k] <= nx_s[k];
                    c_q[k] <= nx_c[k];
                end
            end
            if (rdy[LAST]) begin
                ovf_q <= ovf_nx;
            end
        end
    end

    // Operand bits already consumed by earlier stages are carried but never read again.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{in_a, in_b, a_q[LAST], b_q[LAST]};

    assign o_ready = rdy[0];
    assign o_valid = v_q[LAST];
    assign o_s     = s_q[LAST];
    assign o_co    = c_q[LAST];
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed-vector bench for cla_pipe_adder: default 32-bit/2-group instance plus
// 16-bit/1-group and 8-bit/2-group instances for the parameter sweep.
module tb_cla_pipe_adder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_a = '0;
    logic [31:0] i_b = '0;
    logic        i_ci = 1'b0;
    logic        i_sub = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_s;
    logic        o_co;
    logic        o_ovf;

    logic        w16_i_valid = 1'b0;
    logic        w16_o_ready;
    logic [15:0] w16_i_a = '0;
    logic [15:0] w16_i_b = '0;
    logic        w16_o_valid;
    logic [15:0] w16_o_s;
    logic        w16_o_co;
    logic        w16_o_ovf;

    logic        w8_i_valid = 1'b0;
    logic        w8_o_ready;
    logic [7:0]  w8_i_a = '0;
    logic [7:0]  w8_i_b = '0;
    logic        w8_o_valid;
    logic [7:0]  w8_o_s;
    logic        w8_o_co;
    logic        w8_o_ovf;

    int checks = 0;
    int failures = 0;

    logic [31:0] r_s;
    logic        r_co;
    logic        r_ovf;
    int          r_lat;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(32), .GRP_PER_STG(2)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_ci(i_ci), .i_sub(i_sub),
        .o_valid(o_valid), .i_ready(i_ready), .o_s(o_s), .o_co(o_co), .o_ovf(o_ovf)
    );

    cla_pipe_adder #(.WIDTH(16), .GRP_PER_STG(1)) dut16 (
        .clk(clk), .reset(reset), .i_valid(w16_i_valid), .o_ready(w16_o_ready),
        .i_a(w16_i_a), .i_b(w16_i_b), .i_ci(1'b0), .i_sub(1'b0),
        .o_valid(w16_o_valid), .i_ready(1'b1), .o_s(w16_o_s), .o_co(w16_o_co), .o_ovf(w16_o_ovf)
    );

    cla_pipe_adder #(.WIDTH(8), .GRP_PER_STG(2)) dut8 (
        .clk(clk), .reset(reset), .i_valid(w8_i_valid), .o_ready(w8_o_ready),
        .i_a(w8_i_a), .i_b(w8_i_b), .i_ci(1'b0), .i_sub(1'b0),
        .o_valid(w8_o_valid), .i_ready(1'b1), .o_s(w8_o_s), .o_co(w8_o_co), .o_ovf(w8_o_ovf)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Cycle n = the negedge n cycles after the accepting negedge; o_valid seen at cycle
    // n is taken by the sink at the following rising edge, so latency NSTG gives n = 4.
    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sub);
        @(negedge clk);
        i_valid = 1'b1; i_a = a; i_b = b; i_ci = ci; i_sub = sub;
        r_lat = -1; r_s = 'x; r_co = 1'bx; r_ovf = 1'bx;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            i_valid = 1'b0;
            #1;
            if (o_valid) begin
                r_lat = n; r_s = o_s; r_co = o_co; r_ovf = o_ovf;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({o_valid, o_co, o_ovf} !== 3'b000) begin
            failures++; $display("FAIL reset_flags: got v/co/ovf=%b required 000", {o_valid, o_co, o_ovf});
        end
        checks++;
        if (o_s !== 32'h0) begin
            failures++; $display("FAIL reset_sum: got %h required 00000000", o_s);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready: got %b required 1", o_ready);
        end
    endtask

    task automatic test_full_carry();
        run_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        checks++;
        if (r_lat !== 4) begin failures++; $display("FAIL carry_latency: got %0d required 4", r_lat); end
        checks++;
        if (r_s !== 32'h0) begin failures++; $display("FAIL carry_sum: got %h required 00000000", r_s); end
        checks++;
        if ({r_co, r_ovf} !== 2'b10) begin failures++; $display("FAIL carry_flags: got co/ovf=%b required 10", {r_co, r_ovf}); end
    endtask

    task automatic test_sub_ovf();
        run_one(32'd5, 32'd7, 1'b0, 1'b1);
        checks++;
        if ({r_s, r_co, r_ovf} !== {32'hFFFF_FFFE, 2'b00}) begin
            failures++; $display("FAIL sub_5_7: got s=%h co=%b ovf=%b required s=fffffffe co=0 ovf=0", r_s, r_co, r_ovf);
        end
        run_one(32'h8000_0000, 32'd1, 1'b0, 1'b1);
        checks++;
        if ({r_s, r_co, r_ovf} !== {32'h7FFF_FFFF, 2'b11}) begin
            failures++; $display("FAIL sub_min_1: got s=%h co=%b ovf=%b required s=7fffffff co=1 ovf=1", r_s, r_co, r_ovf);
        end
        run_one(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        checks++;
        if ({r_s, r_co, r_ovf} !== {32'h8000_0000, 2'b01}) begin
            failures++; $display("FAIL add_max_1: got s=%h co=%b ovf=%b required s=80000000 co=0 ovf=1", r_s, r_co, r_ovf);
        end
        run_one(32'd10, 32'd3, 1'b1, 1'b1);
        checks++;
        if (r_s !== 32'h0000_0006) begin
            failures++; $display("FAIL borrow_in: got %h required 00000006", r_s);
        end
        run_one(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        checks++;
        if ({r_s, r_co, r_ovf} !== {32'h2345_678A, 2'b00}) begin
            failures++; $display("FAIL add_carry_in: got s=%h co=%b ovf=%b required s=2345678a co=0 ovf=0", r_s, r_co, r_ovf);
        end
    endtask

    // Six tokens A=i, B=0x10, odd ones subtract; sink stalls on cycles 5..7.
    task automatic test_back_to_back();
        int sent = 0;
        int recv = 0;
        logic [31:0] stall_s = '0;
        logic [31:0] exp_s;
        int extra = 0;
        for (int cyc = 0; cyc < 60 && recv < 6; cyc++) begin
            @(negedge clk);
            i_ready = !(cyc >= 5 && cyc < 8);
            i_ci = 1'b0;
            if (sent < 6) begin
                i_valid = 1'b1; i_a = 32'(sent); i_b = 32'h10; i_sub = sent[0];
            end else begin
                i_valid = 1'b0;
            end
            #1;
            if (cyc == 5) stall_s = o_s;
            if (cyc >= 5 && cyc < 8) begin
                checks++;
                if (o_ready !== 1'b0) begin failures++; $display("FAIL stall_ready cyc%0d: got %b required 0", cyc, o_ready); end
                checks++;
                if (o_valid !== 1'b1 || o_s !== stall_s || o_s !== 32'hFFFF_FFF1) begin
                    failures++; $display("FAIL stall_hold cyc%0d: got v=%b s=%h required v=1 s=fffffff1", cyc, o_valid, o_s);
                end
            end
            if (i_valid && o_ready) sent++;
            if (o_valid && i_ready) begin
                exp_s = recv[0] ? 32'(recv) - 32'h10 : 32'(recv) + 32'h10;
                checks++;
                if (o_s !== exp_s) begin failures++; $display("FAIL b2b_result%0d: got %h required %h", recv, o_s, exp_s); end
                recv++;
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        checks++;
        if (recv !== 6) begin failures++; $display("FAIL b2b_count: got %0d required 6", recv); end
        for (int n = 0; n < 6; n++) begin
            @(negedge clk); #1;
            if (o_valid) extra++;
        end
        checks++;
        if (extra !== 0) begin failures++; $display("FAIL b2b_duplicate: got %0d extra results required 0", extra); end
    endtask

    // Input valid toggles every cycle; each result must trail its acceptance by 4.
    task automatic test_bubbles();
        int acc_cyc[8];
        int sent = 0;
        int recv = 0;
        for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
            @(negedge clk);
            i_sub = 1'b0; i_ci = 1'b0;
            i_valid = (cyc % 2 == 0) && (sent < 8);
            i_a = 32'h100 + 32'(sent); i_b = 32'(sent);
            #1;
            if (o_valid && i_ready) begin
                checks++;
                if (o_s !== 32'h100 + 32'(2 * recv) || cyc - acc_cyc[recv] !== 4) begin
                    failures++;
                    $display("FAIL bubble%0d: got s=%h lat=%0d required s=%h lat=4", recv, o_s, cyc - acc_cyc[recv], 32'h100 + 32'(2 * recv));
                end
                recv++;
            end
            if (i_valid && o_ready) begin
                acc_cyc[sent] = cyc;
                sent++;
            end
        end
        i_valid = 1'b0;
        checks++;
        if (recv !== 8) begin failures++; $display("FAIL bubble_count: got %0d required 8", recv); end
    endtask

    task automatic test_reset_mid();
        int nvalid = 0;
        int first = -1;
        logic [31:0] first_s = '0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            i_valid = 1'b1; i_a = 32'h11 * 32'(t + 1); i_b = 32'h22; i_sub = 1'b0; i_ci = 1'b0;
        end
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({o_valid, o_co, o_ovf} !== 3'b000 || o_s !== 32'h0) begin
            failures++; $display("FAIL midreset_outputs: got v=%b s=%h co=%b ovf=%b required all 0", o_valid, o_s, o_co, o_ovf);
        end
        @(negedge clk);
        reset = 1'b0;
        i_valid = 1'b1; i_a = 32'd2; i_b = 32'd3;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            i_valid = 1'b0;
            #1;
            if (o_valid) begin
                nvalid++;
                if (first < 0) begin first = n; first_s = o_s; end
            end
        end
        checks++;
        if (nvalid !== 1 || first !== 4 || first_s !== 32'd5) begin
            failures++; $display("FAIL midreset_new: got count=%0d lat=%0d s=%h required count=1 lat=4 s=00000005", nvalid, first, first_s);
        end
    endtask

    task automatic test_param_sweep();
        int lat16 = -1;
        int lat8 = -1;
        logic [15:0] s16 = '0;
        logic        co16 = 1'b0;
        logic [7:0]  s8 = '0;
        logic        ovf8 = 1'b0;
        logic        co8 = 1'b0;
        @(negedge clk);
        w16_i_valid = 1'b1; w16_i_a = 16'hFFFF; w16_i_b = 16'h0001;
        w8_i_valid  = 1'b1; w8_i_a  = 8'h7F;    w8_i_b  = 8'h01;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            w16_i_valid = 1'b0; w8_i_valid = 1'b0;
            #1;
            if (w16_o_valid && lat16 < 0) begin lat16 = n; s16 = w16_o_s; co16 = w16_o_co; end
            if (w8_o_valid && lat8 < 0) begin lat8 = n; s8 = w8_o_s; ovf8 = w8_o_ovf; co8 = w8_o_co; end
        end
        checks++;
        if (lat16 !== 4 || s16 !== 16'h0000 || co16 !== 1'b1) begin
            failures++; $display("FAIL sweep_w16: got lat=%0d s=%h co=%b required lat=4 s=0000 co=1", lat16, s16, co16);
        end
        checks++;
        if (lat8 !== 1 || s8 !== 8'h80 || ovf8 !== 1'b1 || co8 !== 1'b0) begin
            failures++; $display("FAIL sweep_w8: got lat=%0d s=%h ovf=%b co=%b required lat=1 s=80 ovf=1 co=0", lat8, s8, ovf8, co8);
        end
    endtask

    initial begin
        test_reset();
        test_full_carry();
        test_sub_ovf();
        test_back_to_back();
        test_bubbles();
        test_reset_mid();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
